// File: rtl/demux_1x8_deser.sv
// Serial-to-parallel collector / 1:WIDTH bit demultiplexer, LSB (lane 0) first,
// with a valid/ready parallel output. Optional parity lane via DEMUX_PARITY_EN.
module demux_1x8_deser #(
    parameter int WIDTH = 8,
`ifdef DEMUX_PARITY_EN
    localparam int IDX_W = $clog2(WIDTH + 1)
`else
    localparam int IDX_W = $clog2(WIDTH)
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             bit_sync,
    output logic             bit_ready,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid,
    input  logic             par_ready,
    output logic [IDX_W-1:0] bit_idx,
    output logic             frame_err
`ifdef DEMUX_PARITY_EN
    ,
    output logic             par_perr
`endif
);

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_FULL    = 1'b1;

`ifdef DEMUX_PARITY_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH);
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
`endif

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_collect;
    logic [WIDTH-1:0] r_par_out;
    logic             r_par_valid;
    logic             r_frame_err;
    logic [IDX_W-1:0] r_idx;

    logic             w_bit_ready;
    logic             w_accept;
    logic             w_slot_free;
    logic             w_resync;
    logic             w_last;
    logic             w_load_new;
    logic             w_release;
    logic [WIDTH-1:0] w_collect_nxt;

    assign w_bit_ready = !rst && (r_state == ST_COLLECT);
    assign w_accept    = bit_valid && w_bit_ready;
    assign w_slot_free = !r_par_valid || par_ready;
    assign w_resync    = w_accept && bit_sync && (r_idx != '0);
    assign w_last      = w_accept && !w_resync && (r_idx == LAST_IDX);
    assign w_load_new  = w_last && w_slot_free;
    assign w_release   = (r_state == ST_FULL) && r_par_valid && par_ready;

    // Lane write; in parity mode the parity index matches no data lane.
    always_comb begin
        w_collect_nxt = r_collect;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_collect_nxt[i] = bit_in;
            end
        end
    end

`ifdef DEMUX_PARITY_EN
    logic r_perr;
    logic r_held_perr;
    logic w_word_perr;

    assign w_word_perr = (^r_collect) ^ bit_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perr      <= 1'b0;
            r_held_perr <= 1'b0;
        end else begin
            if (w_load_new) begin
                r_perr <= w_word_perr;
            end else if (w_release) begin
                r_perr <= r_held_perr;
            end
            if (w_last && !w_slot_free) begin
                r_held_perr <= w_word_perr;
            end
        end
    end

    assign par_perr = r_perr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_COLLECT;
            r_collect   <= '0;
            r_par_out   <= '0;
            r_par_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_idx       <= '0;
        end else begin
            r_frame_err <= w_resync;

            if (w_load_new) begin
                r_par_out   <= w_collect_nxt;
                r_par_valid <= 1'b1;
            end else if (w_release) begin
                r_par_out   <= r_collect;
                r_par_valid <= 1'b1;
            end else if (r_par_valid && par_ready) begin
                r_par_valid <= 1'b0;
            end

            // A completed word that cannot be presented stays in r_collect while FULL.
            if (w_resync) begin
                r_collect <= WIDTH'(bit_in);
                r_idx     <= IDX_W'(1);
            end else if (w_last) begin
                r_collect <= w_collect_nxt;
                r_idx     <= '0;
                if (!w_slot_free) begin
                    r_state <= ST_FULL;
                end
            end else if (w_accept) begin
                r_collect <= w_collect_nxt;
                r_idx     <= r_idx + IDX_W'(1);
            end

            if (w_release) begin
                r_state <= ST_COLLECT;
            end
        end
    end

    assign bit_ready = w_bit_ready;
    assign par_out   = r_par_out;
    assign par_valid = r_par_valid;
    assign bit_idx   = r_idx;
    assign frame_err = r_frame_err;

endmodule
